// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, branch funct3 codes,
// state encoding and opcode classification helpers.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    function automatic logic op_known(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_known = 1'b1;
            default:                           op_known = 1'b0;
        endcase
    endfunction

    // Classes that retire with a register-file write.
    function automatic logic op_writes(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC: op_writes = 1'b1;
            default:                   op_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; sign bit is XLEN-1 for any width.
module branch_cmp
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic            taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        case (i_funct3)
            F3_BEQ:  taken = w_eq;
            F3_BNE:  taken = ~w_eq;
            F3_BLT:  taken = w_lt;
            F3_BGE:  taken = ~w_lt;
            F3_BLTU: taken = w_ltu;
            F3_BGEU: taken = ~w_ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control unit with memory-wait watchdog and sticky bus error.
// Optional CTRL_ILLEGAL_TRAP_EN routes unknown opcodes through a TRAP state.
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      operation,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] data_rs1,
    input  logic [XLEN-1:0] data_rs2,
    output logic            imem_req,
    input  logic            imem_ready,
    output logic            dmem_req,
    input  logic            dmem_ready,
    output logic            ir_we,
    output logic            pc_we,
    output logic            wr_en,
    output logic            load_en,
    output logic            store_en,
    output logic            jmp_en,
    output logic            jmpr_en,
    output logic            jmpb_en,
    output logic            sub_ctrl,
    output logic            shift_ctrl,
    output logic            bus_err,
    output logic            trap,
    output logic [2:0]      state
);

    localparam int             CW      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  W_LIMIT = CW'(WAIT_MAX);

    state_t        r_state;
    logic [CW-1:0] r_wait;
    logic          r_bus_err;
    logic [6:0]    r_opcode;
    logic [2:0]    r_funct3;
    logic [6:0]    r_funct7;

    logic w_rdy;
    logic w_timeout;
    logic w_taken;
    logic w_is_r;
    logic w_is_i;
    logic w_is_load;
    logic w_is_store;

    assign w_is_r     = (r_opcode == OP_R);
    assign w_is_i     = (r_opcode == OP_I);
    assign w_is_load  = (r_opcode == OP_LOAD);
    assign w_is_store = (r_opcode == OP_STORE);

    // Ready only counts while the matching request is outstanding.
    assign w_rdy     = ((r_state == S_FETCH) & imem_ready) | ((r_state == S_MEM) & dmem_ready);
    assign w_timeout = (r_wait == W_LIMIT) & ~w_rdy;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .i_rs1    (data_rs1),
        .i_rs2    (data_rs2),
        .i_funct3 (r_funct3),
        .taken    (w_taken)
    );

    // State sequencing, wait watchdog and instruction field capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_bus_err <= 1'b0;
            r_opcode  <= 7'd0;
            r_funct3  <= 3'd0;
            r_funct7  <= 7'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_rdy) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_DECODE: begin
                    r_opcode <= operation;
                    r_funct3 <= funct3;
                    r_funct7 <= funct7;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    r_state  <= op_known(operation) ? S_EXEC : S_TRAP;
`else
                    r_state  <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (w_is_load | w_is_store) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_rdy) begin
                        r_state <= w_is_store ? S_FETCH : S_WB;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
`endif
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state   <= S_ERR;
                    r_bus_err <= 1'b1;
                end
            endcase
        end
    end

    // Control decode from registered state/opcode; handshake pulses follow ready.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        wr_en      = 1'b0;
        load_en    = 1'b0;
        store_en   = 1'b0;
        jmp_en     = 1'b0;
        jmpr_en    = 1'b0;
        jmpb_en    = 1'b0;
        sub_ctrl   = 1'b0;
        shift_ctrl = 1'b0;
        trap       = 1'b0;
        if (rst) begin
            imem_req = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    sub_ctrl   = w_is_r & (r_funct7 == 7'b0100000);
                    shift_ctrl = r_funct7[5] & (r_funct3[1:0] == 2'b01) & (w_is_r | w_is_i);
                    jmp_en     = (r_opcode == OP_JAL);
                    jmpr_en    = (r_opcode == OP_JALR);
                    jmpb_en    = (r_opcode == OP_BRANCH) & w_taken;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    load_en  = w_is_load;
                    store_en = w_is_store;
                    pc_we    = w_is_store & dmem_ready;
                end
                S_WB: begin
                    wr_en = op_writes(r_opcode);
                    pc_we = 1'b1;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    trap  = 1'b1;
                    pc_we = 1'b1;
                end
`endif
                default: begin
                    trap = 1'b0;
                end
            endcase
        end
    end

    assign bus_err = r_bus_err;
    assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;
    import ctrl_pkg::*;

    localparam logic [14:0] IMEM = 15'h4000;
    localparam logic [14:0] DMEM = 15'h2000;
    localparam logic [14:0] IRWE = 15'h1000;
    localparam logic [14:0] PCWE = 15'h0800;
    localparam logic [14:0] WREN = 15'h0400;
    localparam logic [14:0] LDEN = 15'h0200;
    localparam logic [14:0] STEN = 15'h0100;
    localparam logic [14:0] JMP  = 15'h0080;
    localparam logic [14:0] JMPR = 15'h0040;
    localparam logic [14:0] JMPB = 15'h0020;
    localparam logic [14:0] SUB  = 15'h0010;
    localparam logic [14:0] SHFT = 15'h0008;
    localparam logic [14:0] BERR = 15'h0004;
    localparam logic [14:0] TRP  = 15'h0002;
    localparam logic [14:0] NONE = 15'h0000;

    typedef struct {
        logic [2:0]  st;
        logic [14:0] fl;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  operation = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] data_rs1 = 32'd0;
    logic [31:0] data_rs2 = 32'd0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, ir_we, pc_we, wr_en, load_en, store_en;
    logic        jmp_en, jmpr_en, jmpb_en, sub_ctrl, shift_ctrl, bus_err, trap;
    logic [2:0]  state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mc_ctrl #(.XLEN(32), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .operation(operation), .funct3(funct3), .funct7(funct7),
        .data_rs1(data_rs1), .data_rs2(data_rs2),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .wr_en(wr_en), .load_en(load_en), .store_en(store_en),
        .jmp_en(jmp_en), .jmpr_en(jmpr_en), .jmpb_en(jmpb_en), .sub_ctrl(sub_ctrl),
        .shift_ctrl(shift_ctrl), .bus_err(bus_err), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // Monitor: compare whatever the DUT presents against the next queued expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {imem_req, dmem_req, ir_we, pc_we, wr_en, load_en, store_en,
                   jmp_en, jmpr_en, jmpb_en, sub_ctrl, shift_ctrl, bus_err, trap, 1'b0};
            checks++;
            if ({state, act} !== {e.st, e.fl}) begin
                errors++;
                $display("FAIL %s: got state=%0d flags=%h, expected state=%0d flags=%h",
                         e.nm, state, act, e.st, e.fl);
            end
        end
    end

    task automatic expect_now(input logic ok, input string nm);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: state=%0d bus_err=%b imem_req=%b", nm, state, bus_err, imem_req);
        end
    endtask

    task automatic cyc(input logic im, input logic dm, input logic [2:0] st,
                       input logic [14:0] fl, input string nm, input logic r = 1'b0);
        @(posedge clk);
        #1;
        rst        = r;
        imem_ready = im;
        dmem_ready = dm;
        exp_q.push_back('{st, fl, nm});
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        operation = op;
        funct3    = f3;
        funct7    = f7;
        data_rs1  = a;
        data_rs2  = b;
    endtask

    task automatic front(input string nm);
        cyc(1'b1, 1'b0, S_FETCH, IMEM | IRWE, {nm, "_fetch"});
        cyc(1'b1, 1'b1, S_DECODE, NONE, {nm, "_decode_rdy_ignored"});
    endtask

    initial begin
        cyc(1'b0, 1'b0, S_FETCH, NONE, "reset_state", 1'b1);
        expect_now((state == S_FETCH) && (bus_err == 1'b0) && (imem_req == 1'b0),
                   "reset_state_direct");

        instr(OP_R, 3'b000, 7'b0000000, 32'd3, 32'd4);
        front("add");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "add_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "add_wb");

        instr(OP_R, 3'b000, 7'b0100000, 32'd3, 32'd4);
        front("sub");
        cyc(1'b0, 1'b0, S_EXEC, SUB, "sub_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "sub_wb");

        instr(OP_R, 3'b101, 7'b0100000, 32'd3, 32'd4);
        front("sra");
        cyc(1'b0, 1'b0, S_EXEC, SUB | SHFT, "sra_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "sra_wb");

        instr(OP_I, 3'b001, 7'b0100000, 32'd3, 32'd4);
        front("ishift");
        cyc(1'b0, 1'b0, S_EXEC, SHFT, "ishift_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "ishift_wb");

        instr(OP_BRANCH, F3_BLT, 7'd0, 32'hFFFF_FFFF, 32'd1);
        front("blt");
        cyc(1'b0, 1'b0, S_EXEC, JMPB, "blt_exec_taken");
        cyc(1'b0, 1'b0, S_WB, PCWE, "blt_wb");

        instr(OP_BRANCH, F3_BLTU, 7'd0, 32'hFFFF_FFFF, 32'd1);
        front("bltu");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "bltu_exec_not_taken");
        cyc(1'b0, 1'b0, S_WB, PCWE, "bltu_wb");

        instr(OP_BRANCH, F3_BGEU, 7'd0, 32'hFFFF_FFFF, 32'd1);
        front("bgeu");
        cyc(1'b0, 1'b0, S_EXEC, JMPB, "bgeu_exec_taken");
        cyc(1'b0, 1'b0, S_WB, PCWE, "bgeu_wb");

        instr(OP_BRANCH, 3'b010, 7'd0, 32'd5, 32'd5);
        front("b010");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "b010_exec_not_taken");
        cyc(1'b0, 1'b0, S_WB, PCWE, "b010_wb");

        instr(OP_JAL, 3'd0, 7'd0, 32'd0, 32'd0);
        front("jal");
        cyc(1'b0, 1'b0, S_EXEC, JMP, "jal_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "jal_wb");

        instr(OP_JALR, 3'd0, 7'd0, 32'd0, 32'd0);
        front("jalr");
        cyc(1'b0, 1'b0, S_EXEC, JMPR, "jalr_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "jalr_wb");

        instr(OP_LOAD, 3'b010, 7'd0, 32'd0, 32'd0);
        front("ld");
        cyc(1'b0, 1'b1, S_EXEC, NONE, "ld_exec_rdy_ignored");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, S_MEM, DMEM | LDEN, "ld_mem_stall");
        cyc(1'b0, 1'b1, S_MEM, DMEM | LDEN, "ld_mem_ready");
        cyc(1'b1, 1'b0, S_WB, WREN | PCWE, "ld_wb");

        instr(OP_STORE, 3'b010, 7'd0, 32'd0, 32'd0);
        front("st");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "st_exec");
        cyc(1'b0, 1'b1, S_MEM, DMEM | STEN | PCWE, "st_mem_ready");

        instr(7'b1111111, 3'd0, 7'd0, 32'd0, 32'd0);
        front("illegal");
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(1'b0, 1'b0, S_TRAP, TRP | PCWE, "illegal_trap");
`else
        cyc(1'b0, 1'b0, S_EXEC, NONE, "illegal_exec_nop");
        cyc(1'b0, 1'b0, S_WB, PCWE, "illegal_wb_nop");
`endif

        // Ready arriving exactly at the WAIT_MAX count is still accepted.
        instr(OP_R, 3'b000, 7'd0, 32'd0, 32'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, S_FETCH, IMEM, "fetch_stall");
        cyc(1'b1, 1'b0, S_FETCH, IMEM | IRWE, "fetch_ready_at_limit");
        cyc(1'b0, 1'b0, S_DECODE, NONE, "limit_decode");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "limit_exec");
        cyc(1'b0, 1'b0, S_WB, WREN | PCWE, "limit_wb");

        instr(OP_STORE, 3'b010, 7'd0, 32'd0, 32'd0);
        front("strst");
        cyc(1'b0, 1'b0, S_EXEC, NONE, "strst_exec");
        cyc(1'b0, 1'b0, S_MEM, DMEM | STEN, "strst_mem");
        cyc(1'b0, 1'b1, S_FETCH, NONE, "strst_in_reset", 1'b1);
        cyc(1'b0, 1'b0, S_FETCH, IMEM, "strst_after_reset");

        // Remaining fetch cycles until the watchdog expires after 16 cycles in FETCH.
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, S_FETCH, IMEM, "err_stall");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, S_ERR, BERR, "err_sticky");
        expect_now((state == S_ERR) && (bus_err == 1'b1), "expired_wait_direct");
        cyc(1'b0, 1'b0, S_FETCH, NONE, "err_reset", 1'b1);
        cyc(1'b0, 1'b0, S_FETCH, IMEM, "err_cleared");

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
